// File: rtl/uart_fifo_controller.sv
// UART controller with TX/RX FIFOs, configurable frame format and sticky error status.
// Frames carry data[UART_NBIT-1:0], LSB first; bus side is DATA_WIDTH wide.
module uart_fifo_controller #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned UART_NBIT  = 8,
   parameter int unsigned CLK_FREQ   = 50,
   parameter int unsigned BAUDRATE   = 5,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          SerialDataIn,
   output logic                          SerialDataOut,
   input  logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_push,
   input  logic                          rx_pop,
   input  logic                          clr_err,
   output logic [DATA_WIDTH-1:0]         rx_data,
   output logic [DATA_WIDTH-1:0]         status,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   output logic [$clog2(FIFO_DEPTH):0]   tx_level
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam int unsigned BW = $clog2(UART_NBIT);

   localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CntMid  = CW'(CLKS_PER_BIT / 2);
   localparam logic [BW-1:0] BitLast = BW'(UART_NBIT - 1);
   localparam logic [LW-1:0] DepthL  = LW'(FIFO_DEPTH);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StStart  = 3'd1;
   localparam logic [2:0] StData   = 3'd2;
   localparam logic [2:0] StParity = 3'd3;
   localparam logic [2:0] StStop   = 3'd4;

   // Upper tx_data bits are intentionally ignored.
   logic unused_tx_bits;
   assign unused_tx_bits = ^tx_data[DATA_WIDTH-1:UART_NBIT];

   // ---------------------------------------------------------------- TX FIFO
   logic [UART_NBIT-1:0] tx_mem [FIFO_DEPTH];
   logic [PW-1:0]        tx_wr_q, tx_rd_q;
   logic [LW-1:0]        tx_cnt_q;
   logic                 tx_full, tx_empty, tx_pop, tx_pop_ok, tx_push_ok;
   logic [UART_NBIT-1:0] tx_head;

   assign tx_full    = (tx_cnt_q == DepthL);
   assign tx_empty   = (tx_cnt_q == '0);
   assign tx_pop_ok  = tx_pop & ~tx_empty;
   // A push into a full FIFO is accepted when the FSM pops in the same cycle.
   assign tx_push_ok = tx_push & (~tx_full | tx_pop_ok);
   assign tx_head    = tx_mem[tx_rd_q];

   // TX FIFO storage (no reset needed; occupancy guards reads)
   always_ff @(posedge clk) begin
      if (tx_push_ok) tx_mem[tx_wr_q] <= tx_data[UART_NBIT-1:0];
   end

   // TX FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         tx_cnt_q <= '0;
      end else begin
         if (tx_push_ok) tx_wr_q <= tx_wr_q + PW'(1);
         if (tx_pop_ok)  tx_rd_q <= tx_rd_q + PW'(1);
         tx_cnt_q <= tx_cnt_q + LW'(tx_push_ok) - LW'(tx_pop_ok);
      end
   end

   // ---------------------------------------------------------------- TX FSM
   logic [2:0]           tx_state_q;
   logic [CW-1:0]        tx_baud_q;
   logic [BW-1:0]        tx_bit_q;
   logic                 tx_stop_q;
   logic [UART_NBIT-1:0] tx_shift_q;
   logic                 tx_par_q;
   logic                 tx_line_q;
   logic                 tx_bit_end, tx_last_stop;

   assign tx_bit_end   = (tx_baud_q == CntLast);
   assign tx_last_stop = (tx_stop_q == 1'(STOP_BITS - 1));

   // Pop on leaving idle, or at the end of the final stop bit when more data waits.
   always_comb begin
      tx_pop = 1'b0;
      if (tx_state_q == StIdle && !tx_empty) tx_pop = 1'b1;
      if (tx_state_q == StStop && tx_bit_end && tx_last_stop && !tx_empty) tx_pop = 1'b1;
   end

   // TX frame sequencing; line level is registered so each bit lasts CLKS_PER_BIT cycles
   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_state_q <= StIdle;
         tx_baud_q  <= '0;
         tx_bit_q   <= '0;
         tx_stop_q  <= 1'b0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_line_q  <= 1'b1;
      end else begin
         if (tx_state_q != StIdle) tx_baud_q <= tx_bit_end ? '0 : tx_baud_q + CW'(1);
         case (tx_state_q)
            StIdle: begin
               if (!tx_empty) begin
                  tx_state_q <= StStart;
                  tx_line_q  <= 1'b0;
                  tx_shift_q <= tx_head;
                  tx_par_q   <= ^tx_head ^ 1'(PARITY_ODD);
               end
            end
            StStart: begin
               if (tx_bit_end) begin
                  tx_state_q <= StData;
                  tx_bit_q   <= '0;
                  tx_line_q  <= tx_shift_q[0];
               end
            end
            StData: begin
               if (tx_bit_end) begin
                  if (tx_bit_q == BitLast) begin
                     if (PARITY_EN != 0) begin
                        tx_state_q <= StParity;
                        tx_line_q  <= tx_par_q;
                     end else begin
                        tx_state_q <= StStop;
                        tx_stop_q  <= 1'b0;
                        tx_line_q  <= 1'b1;
                     end
                  end else begin
                     tx_bit_q   <= tx_bit_q + BW'(1);
                     tx_shift_q <= {1'b0, tx_shift_q[UART_NBIT-1:1]};
                     tx_line_q  <= tx_shift_q[1];
                  end
               end
            end
            StParity: begin
               if (tx_bit_end) begin
                  tx_state_q <= StStop;
                  tx_stop_q  <= 1'b0;
                  tx_line_q  <= 1'b1;
               end
            end
            StStop: begin
               if (tx_bit_end) begin
                  if (!tx_last_stop) begin
                     tx_stop_q <= 1'b1;
                  end else if (!tx_empty) begin
                     tx_state_q <= StStart;
                     tx_line_q  <= 1'b0;
                     tx_shift_q <= tx_head;
                     tx_par_q   <= ^tx_head ^ 1'(PARITY_ODD);
                  end else begin
                     tx_state_q <= StIdle;
                     tx_line_q  <= 1'b1;
                  end
               end
            end
            default: begin
               tx_state_q <= StIdle;
               tx_line_q  <= 1'b1;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- RX path
   logic rx_sync1_q, rx_s, rx_prev_q;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_sync1_q <= 1'b1;
         rx_s       <= 1'b1;
         rx_prev_q  <= 1'b1;
      end else begin
         rx_sync1_q <= SerialDataIn;
         rx_s       <= rx_sync1_q;
         rx_prev_q  <= rx_s;
      end
   end

   logic [2:0]           rx_state_q;
   logic [CW-1:0]        rx_baud_q;
   logic [BW-1:0]        rx_bit_q;
   logic [UART_NBIT-1:0] rx_shift_q;
   logic                 rx_mid, rx_end, rx_store, rx_par_evt, rx_frame_evt;

   assign rx_mid       = (rx_baud_q == CntMid);
   assign rx_end       = (rx_baud_q == CntLast);
   assign rx_store     = (rx_state_q == StStop) && rx_mid;
   assign rx_frame_evt = rx_store && !rx_s;
   assign rx_par_evt   = (PARITY_EN != 0) && (rx_state_q == StParity) && rx_mid &&
                         ((^rx_shift_q ^ rx_s) != 1'(PARITY_ODD));

   // RX frame sequencing; leaves STOP right after its mid-bit sample to resync early
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_state_q <= StIdle;
         rx_baud_q  <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         if (rx_state_q != StIdle) rx_baud_q <= rx_end ? '0 : rx_baud_q + CW'(1);
         case (rx_state_q)
            StIdle: begin
               if (!rx_s && rx_prev_q) rx_state_q <= StStart;
            end
            StStart: begin
               if (rx_mid && rx_s) begin
                  // Line back high before mid-bit: glitch, not a start bit.
                  rx_state_q <= StIdle;
                  rx_baud_q  <= '0;
               end else if (rx_end) begin
                  rx_state_q <= StData;
                  rx_bit_q   <= '0;
               end
            end
            StData: begin
               if (rx_mid) rx_shift_q <= {rx_s, rx_shift_q[UART_NBIT-1:1]};
               if (rx_end) begin
                  if (rx_bit_q == BitLast) begin
                     rx_state_q <= (PARITY_EN != 0) ? StParity : StStop;
                  end else begin
                     rx_bit_q <= rx_bit_q + BW'(1);
                  end
               end
            end
            StParity: begin
               if (rx_end) rx_state_q <= StStop;
            end
            StStop: begin
               if (rx_mid) begin
                  rx_state_q <= StIdle;
                  rx_baud_q  <= '0;
               end
            end
            default: rx_state_q <= StIdle;
         endcase
      end
   end

   // ---------------------------------------------------------------- RX FIFO
   logic [UART_NBIT-1:0] rx_mem [FIFO_DEPTH];
   logic [PW-1:0]        rx_wr_q, rx_rd_q;
   logic [LW-1:0]        rx_cnt_q;
   logic                 rx_full, rx_empty, rx_pop_ok, rx_push_ok, rx_ovr_evt;

   assign rx_full    = (rx_cnt_q == DepthL);
   assign rx_empty   = (rx_cnt_q == '0);
   assign rx_pop_ok  = rx_pop & ~rx_empty;
   assign rx_push_ok = rx_store & (~rx_full | rx_pop_ok);
   assign rx_ovr_evt = rx_store & ~rx_push_ok;

   // RX FIFO storage
   always_ff @(posedge clk) begin
      if (rx_push_ok) rx_mem[rx_wr_q] <= rx_shift_q;
   end

   // RX FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (rx_push_ok) rx_wr_q <= rx_wr_q + PW'(1);
         if (rx_pop_ok)  rx_rd_q <= rx_rd_q + PW'(1);
         rx_cnt_q <= rx_cnt_q + LW'(rx_push_ok) - LW'(rx_pop_ok);
      end
   end

   // ---------------------------------------------------------------- status
   logic [2:0] err_q;  // {overrun, frame_err, parity_err}

   // Sticky errors; a new error in the same cycle as clr_err survives the clear
   always_ff @(posedge clk) begin
      if (!reset) begin
         err_q <= '0;
      end else begin
         err_q <= (clr_err ? 3'b000 : err_q) | {rx_ovr_evt, rx_frame_evt, rx_par_evt};
      end
   end

   // Bus-side outputs
   always_comb begin
      status      = '0;
      status[0]   = rx_empty;
      status[1]   = rx_full;
      status[2]   = tx_empty;
      status[3]   = tx_full;
      status[4]   = (tx_state_q != StIdle);
      status[7:5] = err_q;
      rx_data     = '0;
      if (!rx_empty) rx_data[UART_NBIT-1:0] = rx_mem[rx_rd_q];
   end

   assign SerialDataOut = tx_line_q;
   assign rx_level      = rx_cnt_q;
   assign tx_level      = tx_cnt_q;

endmodule

// File: tb/tb_uart_fifo_controller.sv
// Directed bench for uart_fifo_controller: three instances (8N1, 8O2, 8E1), 10 clk/bit.
module tb_uart_fifo_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Index 0: 8N1, 1: 8O2, 2: 8E1
   logic        rst_n [3];
   logic        sdi   [3];
   logic        sdo   [3];
   logic [31:0] txd   [3];
   logic        push  [3];
   logic        pop   [3];
   logic        clr   [3];
   logic [31:0] rxd   [3];
   logic [31:0] st    [3];
   logic [2:0]  rxl   [3];
   logic [2:0]  txl   [3];

   int n_cmp = 0;
   int n_err = 0;

   uart_fifo_controller #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .reset(rst_n[0]), .SerialDataIn(sdi[0]), .SerialDataOut(sdo[0]),
      .tx_data(txd[0]), .tx_push(push[0]), .rx_pop(pop[0]), .clr_err(clr[0]),
      .rx_data(rxd[0]), .status(st[0]), .rx_level(rxl[0]), .tx_level(txl[0]));

   uart_fifo_controller #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_8o2 (
      .clk(clk), .reset(rst_n[1]), .SerialDataIn(sdi[1]), .SerialDataOut(sdo[1]),
      .tx_data(txd[1]), .tx_push(push[1]), .rx_pop(pop[1]), .clr_err(clr[1]),
      .rx_data(rxd[1]), .status(st[1]), .rx_level(rxl[1]), .tx_level(txl[1]));

   uart_fifo_controller #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .reset(rst_n[2]), .SerialDataIn(sdi[2]), .SerialDataOut(sdo[2]),
      .tx_data(txd[2]), .tx_push(push[2]), .rx_pop(pop[2]), .clr_err(clr[2]),
      .rx_data(rxd[2]), .status(st[2]), .rx_level(rxl[2]), .tx_level(txl[2]));

   // One posedge, then park on the following negedge (sample and drive point).
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input int u);
      rst_n[u] = 1'b0;
      step(2);
      rst_n[u] = 1'b1;
      step(1);
   endtask

   // Drive one frame on RX line u: start, 8 data LSB first, optional parity, stops.
   task automatic send_frame(input int u, input logic [7:0] d, input bit par_en,
                             input logic par, input int nstop, input logic stop0);
      sdi[u] = 1'b0;
      step(10);
      for (int i = 0; i < 8; i++) begin
         sdi[u] = d[i];
         step(10);
      end
      if (par_en) begin
         sdi[u] = par;
         step(10);
      end
      sdi[u] = stop0;
      step(10);
      for (int i = 1; i < nstop; i++) begin
         sdi[u] = 1'b1;
         step(10);
      end
      sdi[u] = 1'b1;
   endtask

   // Wait (bounded) for a start bit on TX line u, then sample n bits at mid-bit.
   // bits[i] is the i-th bit in time order. Returns parked at the last sample.
   task automatic capture(input int u, input int n, input string tag,
                          output logic [31:0] bits);
      int waited = 0;
      bits = '0;
      while (sdo[u] !== 1'b0 && waited < 400) begin
         step(1);
         waited++;
      end
      check_eq({tag, "_start_seen"}, 32'(sdo[u]), 32'h0);
      step(5);
      for (int i = 0; i < n; i++) begin
         bits[i] = sdo[u];
         if (i < n - 1) step(10);
      end
   endtask

   task automatic pop_one(input int u);
      pop[u] = 1'b1;
      step(1);
      pop[u] = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   logic [31:0] bits;

   initial begin
      for (int u = 0; u < 3; u++) begin
         rst_n[u] = 1'b0;
         sdi[u]   = 1'b1;
         txd[u]   = '0;
         push[u]  = 1'b0;
         pop[u]   = 1'b0;
         clr[u]   = 1'b0;
      end
      @(negedge clk);
      step(2);
      for (int u = 0; u < 3; u++) rst_n[u] = 1'b1;
      step(1);

      // Reset state on every instance
      for (int u = 0; u < 3; u++) begin
         check_eq($sformatf("rst_status%0d", u), st[u], 32'h5);
         check_eq($sformatf("rst_rxdata%0d", u), rxd[u], 32'h0);
         check_eq($sformatf("rst_levels%0d", u), {rxl[u], txl[u]}, 32'h0);
         check_eq($sformatf("rst_sdo%0d", u), 32'(sdo[u]), 32'h1);
      end

      // 1: RX line 0,1,0,0,1,1,1,0,0,1 -> 0x39
      send_frame(0, 8'h39, 1'b0, 1'b0, 1, 1'b1);
      step(2);
      check_eq("rx1_data", rxd[0], 32'h39);
      check_eq("rx1_level", 32'(rxl[0]), 32'd1);
      check_eq("rx1_status", st[0], 32'h4);
      pop_one(0);
      check_eq("rx1_pop_status", st[0], 32'h5);
      check_eq("rx1_pop_level", 32'(rxl[0]), 32'd0);

      // 2: TX two words back to back
      push[0] = 1'b1;
      txd[0]  = 32'h12345678;
      step(1);
      check_eq("tx2_level_after_push", 32'(txl[0]), 32'd1);
      check_eq("tx2_idle_line", 32'(sdo[0]), 32'h1);
      txd[0] = 32'h000000AB;
      step(1);
      push[0] = 1'b0;
      check_eq("tx2_start_line", 32'(sdo[0]), 32'h0);
      check_eq("tx2_busy", 32'(st[0][4]), 32'h1);
      check_eq("tx2_level_pushpop", 32'(txl[0]), 32'd1);
      capture(0, 20, "tx2", bits);
      // time order: 0 00011110 1 0 11010101 1
      check_eq("tx2_bits", bits, {12'h0, 1'b1, 8'hAB, 1'b0, 1'b1, 8'h78, 1'b0});
      step(4);
      check_eq("tx2_busy_last_stop", 32'(st[0][4]), 32'h1);
      step(1);
      check_eq("tx2_busy_drop", 32'(st[0][4]), 32'h0);
      check_eq("tx2_line_idle", 32'(sdo[0]), 32'h1);

      // 3a: 8O2 TX 0x07 -> parity 0, two stop bits
      push[1] = 1'b1;
      txd[1]  = 32'h07;
      step(1);
      push[1] = 1'b0;
      capture(1, 12, "tx3o", bits);
      check_eq("tx3o_bits", bits, {20'h0, 2'b11, 1'b0, 8'h07, 1'b0});
      step(4);
      check_eq("tx3o_busy_2nd_stop", 32'(st[1][4]), 32'h1);
      step(1);
      check_eq("tx3o_busy_drop", 32'(st[1][4]), 32'h0);

      // 3b: 8E1 TX 0x07 -> parity 1
      push[2] = 1'b1;
      txd[2]  = 32'h07;
      step(1);
      push[2] = 1'b0;
      capture(2, 11, "tx3e", bits);
      check_eq("tx3e_bits", bits, {21'h0, 1'b1, 1'b1, 8'h07, 1'b0});

      // 3c: 8O2 RX good parity (0x5A has four ones -> odd parity bit 1)
      send_frame(1, 8'h5A, 1'b1, 1'b1, 2, 1'b1);
      step(2);
      check_eq("rx3o_data", rxd[1], 32'h5A);
      check_eq("rx3o_status", st[1], 32'h4);

      // 3d: 8E1 RX bad parity, then bad stop bit
      send_frame(2, 8'h07, 1'b1, 1'b0, 1, 1'b1);
      step(2);
      check_eq("rx3e_par_data", rxd[2], 32'h07);
      check_eq("rx3e_par_status", st[2], 32'h24);
      pop_one(2);
      send_frame(2, 8'h42, 1'b1, 1'b0, 1, 1'b0);
      step(2);
      check_eq("rx3e_frm_data", rxd[2], 32'h42);
      check_eq("rx3e_frm_status", st[2], 32'h64);
      clr[2] = 1'b1;
      step(1);
      clr[2] = 1'b0;
      check_eq("rx3e_clr_status", st[2], 32'h04);

      // 4a: RX overrun on 8N1 (D+1 frames, no pop)
      do_reset(0);
      send_frame(0, 8'h11, 1'b0, 1'b0, 1, 1'b1);
      send_frame(0, 8'h22, 1'b0, 1'b0, 1, 1'b1);
      send_frame(0, 8'h33, 1'b0, 1'b0, 1, 1'b1);
      send_frame(0, 8'h44, 1'b0, 1'b0, 1, 1'b1);
      send_frame(0, 8'h55, 1'b0, 1'b0, 1, 1'b1);
      step(2);
      check_eq("ovr_level", 32'(rxl[0]), 32'd4);
      check_eq("ovr_status", st[0], 32'h86);
      check_eq("ovr_head0", rxd[0], 32'h11);
      pop_one(0);
      check_eq("ovr_head1", rxd[0], 32'h22);
      pop_one(0);
      check_eq("ovr_head2", rxd[0], 32'h33);
      pop_one(0);
      check_eq("ovr_head3", rxd[0], 32'h44);
      pop_one(0);
      check_eq("ovr_empty", st[0], 32'h85);

      // 4b: TX FIFO full, push ignored, then push coincident with the FSM pop
      do_reset(0);
      push[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         txd[0] = 32'hA0 + 32'(i);
         step(1);
      end
      // first pop happened on the second push edge (E1); now after E1+3
      push[0] = 1'b0;
      check_eq("txfull_level", 32'(txl[0]), 32'd4);
      check_eq("txfull_flag", 32'(st[0][3]), 32'h1);
      step(95);
      push[0] = 1'b1;
      txd[0]  = 32'hA5;
      step(1);
      check_eq("txfull_push_ignored", 32'(txl[0]), 32'd4);
      txd[0] = 32'hA6;
      step(1);
      push[0] = 1'b0;
      check_eq("txfull_pushpop_level", 32'(txl[0]), 32'd4);
      capture(0, 10, "txq1", bits);
      check_eq("txq1_bits", bits, {22'h0, 1'b1, 8'hA1, 1'b0});
      capture(0, 10, "txq2", bits);
      check_eq("txq2_bits", bits, {22'h0, 1'b1, 8'hA2, 1'b0});
      capture(0, 10, "txq3", bits);
      check_eq("txq3_bits", bits, {22'h0, 1'b1, 8'hA3, 1'b0});
      capture(0, 10, "txq4", bits);
      check_eq("txq4_bits", bits, {22'h0, 1'b1, 8'hA4, 1'b0});
      capture(0, 10, "txq5", bits);
      check_eq("txq5_bits", bits, {22'h0, 1'b1, 8'hA6, 1'b0});
      step(10);

      // 5a: 3-clk glitch on idle RX line
      do_reset(0);
      sdi[0] = 1'b0;
      step(3);
      sdi[0] = 1'b1;
      step(30);
      check_eq("glitch_level", 32'(rxl[0]), 32'd0);
      check_eq("glitch_status", st[0], 32'h5);

      // 5b: reset in the middle of TX data bits
      push[0] = 1'b1;
      txd[0]  = 32'h00;
      step(2);
      push[0] = 1'b0;
      step(30);
      check_eq("rstmid_line_low", 32'(sdo[0]), 32'h0);
      check_eq("rstmid_level_before", 32'(txl[0]), 32'd1);
      rst_n[0] = 1'b0;
      step(1);
      check_eq("rstmid_line", 32'(sdo[0]), 32'h1);
      check_eq("rstmid_level", 32'(txl[0]), 32'd0);
      check_eq("rstmid_status", st[0], 32'h5);
      rst_n[0] = 1'b1;
      step(20);
      check_eq("rstmid_after_line", 32'(sdo[0]), 32'h1);
      check_eq("rstmid_after_status", st[0], 32'h5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
